uart_tx_core: RTL and testbench
===============================

# uart_tx_core

Serial UART transmitter: converts one parallel byte into an asynchronous 8N1 frame on a single output line, one bit every `CLK_PER_BAUD` clock cycles. It sits between the byte-producing logic and the board TX pin. It signals frame completion with a one-cycle `done` pulse.

## Interface
- `CLK_PER_BAUD`, default 4 — clock cycles per serial bit; legal range ≥ 2.
- `clk`  input  1  — system clock; all logic is rising-edge.
- `rst`  input  1  — reset, asynchronous, active-low.
- `tx_byte`  input  8  — byte to send; sampled only when a frame is accepted.
- `start_send`  input  1  — level request to transmit; checked in IDLE.
- `tx`  output  1  — serial line, registered, idle high.
- `done`  output  1  — one-cycle pulse on the last cycle of the stop bit.

## Operation
- Frame format: start bit (0), 8 data bits LSB first, stop bit (1).
- States:
  - IDLE: `tx`=1. On an edge where `start_send`=1, latch `tx_byte` into a shift register, clear the baud counter and go to START.
  - START: `tx`=0 for `CLK_PER_BAUD` cycles, then go to DATA with bit index 0.
  - DATA: `tx`=shift[0] for `CLK_PER_BAUD` cycles per bit, shifting right after each bit. After bit index 7, go to STOP.
  - STOP: `tx`=1 for `CLK_PER_BAUD` cycles. `done`=1 on the final cycle, then return to IDLE.
- `start_send` and `tx_byte` are ignored outside IDLE; changing `tx_byte` mid-frame does not affect the frame in flight.
- If `start_send` is held high, frames repeat back-to-back, each starting from a fresh `tx_byte` sample.
- Reset:
  - Asserting `rst` (low) at any time, including mid-frame, forces IDLE immediately and asynchronously.
  - During and after reset: `tx`=1, `done`=0, counters=0, shift register=0.
  - A partial frame is abandoned; no `done` pulse is produced.
- Baud counter width is `$clog2(CLK_PER_BAUD)`. It counts 0..`CLK_PER_BAUD`-1 and wraps to 0 at each bit boundary.

## Timing
- Request at edge N (IDLE, `start_send`=1) → `tx` low from edge N through N+`CLK_PER_BAUD`.
- Data bit k occupies `tx` from N+(1+k)·`CLK_PER_BAUD` to N+(2+k)·`CLK_PER_BAUD`.
- Stop bit occupies `tx` from N+9·`CLK_PER_BAUD` to N+10·`CLK_PER_BAUD`.
- `done` is high for exactly the cycle ending at edge N+10·`CLK_PER_BAUD`.
- State is IDLE after edge N+10·`CLK_PER_BAUD`. The earliest next acceptance is edge N+10·`CLK_PER_BAUD`+1.
- Continuous-request period is therefore 10·`CLK_PER_BAUD`+1 cycles, with 1 idle-high cycle between frames.
- `done` and `tx` are both registered outputs; there is no combinational path from inputs to outputs.

## Configuration
- Macro `UART_TX_PARITY_EN`.
  - Defined: a PARITY state is inserted between DATA and STOP. It drives the even-parity bit (XOR of the 8 latched data bits) for `CLK_PER_BAUD` cycles. The frame becomes 11 bits and all STOP/`done` timings shift by `CLK_PER_BAUD`.
  - Undefined: 8N1 exactly as above. No parity logic is synthesized.

## Structure
- Shared package `uart_pkg`:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - `UART_DATA_BITS`=8;
  - start/stop bit level constants.
  - Reused by the future receiver.
- One natural sub-module: `uart_baud_tick`. It is a parameterized counter with a clear input and a one-cycle `tick` output every `CLK_PER_BAUD` cycles; the FSM advances only on `tick`.

## Test plan
All scenarios use `CLK_PER_BAUD`=4.
- Reset: hold `rst`=0 for 3 cycles with `start_send`=1 → `tx`=1 and `done`=0 throughout; no frame starts until `rst`=1.
- Single frame: `tx_byte`=0x30, `start_send` pulsed 1 cycle. Expected `tx` at 4-cycle steps: 0, 0,0,0,0,1,1,0,0, 1. Then `done`=1 for one cycle, 40 cycles after acceptance.
- Continuous send: `start_send` held 1, `tx_byte`=0x30 → identical frames every 41 cycles, each preceded by one idle-high cycle; exactly one `done` pulse per frame.
- Mid-frame data change: `tx_byte` switches 0x30→0xFF during DATA → current frame still carries 0x30; the next frame carries 0xFF.
- Mid-frame reset: `rst`=0 at data bit 3 → `tx`=1 in the same cycle, no `done`; after release and a new request, a full frame is sent correctly.
- Boundary: `tx_byte`=0x00 and 0xFF → `tx` low for 36 cycles then high 4, and low for 4 then high 36, respectively.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and the future receiver.
// Holds the frame geometry, the line levels for start/stop bits and the FSM
// state encoding.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;

  localparam logic UART_START_BIT = 1'b0;
  localparam logic UART_STOP_BIT  = 1'b1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    UART_IDLE   = ST_IDLE,
    UART_START  = ST_START,
    UART_DATA   = ST_DATA,
    UART_PARITY = ST_PARITY,
    UART_STOP   = ST_STOP
  } uart_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Baud-rate divider: counts 0..CLK_PER_BAUD-1 and raises a registered one-cycle
// tick on the last cycle of every bit period.
//   clk    - system clock
//   rst    - asynchronous active-low reset
//   clear  - hold the counter at 0 (used while the line is idle)
//   cnt    - current position inside the bit period
//   tick   - high during the final cycle of each bit period
module uart_baud_tick #(
  parameter  int unsigned CLK_PER_BAUD = 4,
  localparam int unsigned CNT_W        = (CLK_PER_BAUD > 1) ? $clog2(CLK_PER_BAUD) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  output logic [CNT_W-1:0] cnt,
  output logic             tick
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_PER_BAUD - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Next count; tick is registered from the next count so it lines up with cnt==last.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (clear || (cnt_q == CNT_LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    tick_d = (cnt_d == CNT_LAST);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign cnt  = cnt_q;
  assign tick = tick_q;

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: serialises one byte per request into an 8N1 frame
// (start, 8 data bits LSB first, stop) with CLK_PER_BAUD clocks per bit.
// Optional macro UART_TX_PARITY_EN inserts an even-parity bit before stop.
//   clk        - system clock
//   rst        - asynchronous active-low reset
//   tx_byte    - byte to send, sampled when a frame is accepted
//   start_send - level request, honoured only while idle
//   tx         - registered serial line, idle high
//   done       - registered one-cycle pulse on the last stop-bit cycle
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int unsigned CLK_PER_BAUD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_byte,
  input  logic       start_send,
  output logic       tx,
  output logic       done
);

  localparam int unsigned CNT_W = (CLK_PER_BAUD > 1) ? $clog2(CLK_PER_BAUD) : 1;
  localparam int unsigned IDX_W = $clog2(UART_DATA_BITS);

  logic [2:0]                state_q, state_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic                      tx_q, tx_d;
  logic                      done_q, done_d;
  logic [CNT_W-1:0]          baud_cnt;
  logic                      baud_tick;
`ifdef UART_TX_PARITY_EN
  logic                      parity_q, parity_d;
`endif

  // Bit timer is held at zero while idle so each frame starts on a fresh period.
  uart_baud_tick #(
    .CLK_PER_BAUD(CLK_PER_BAUD)
  ) u_baud_tick (
    .clk  (clk),
    .rst  (rst),
    .clear(state_q == ST_IDLE),
    .cnt  (baud_cnt),
    .tick (baud_tick)
  );

  // Next-state, datapath and output decode.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    tx_d    = UART_STOP_BIT;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start_send) begin
          state_d = ST_START;
          shift_d = tx_byte;
          idx_d   = '0;
`ifdef UART_TX_PARITY_EN
          parity_d = ^tx_byte;
`endif
        end
      end
      ST_START: begin
        if (baud_tick) begin
          state_d = ST_DATA;
          idx_d   = '0;
        end
      end
      ST_DATA: begin
        if (baud_tick) begin
          shift_d = shift_q >> 1;
          if (idx_q == IDX_W'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (baud_tick) begin
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        // Registered, so flag the cycle before the final one.
        done_d = (baud_cnt == CNT_W'(CLK_PER_BAUD - 2));
        if (baud_tick) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // tx is registered from the state being entered, so it changes on the bit edge.
    case (state_d)
      ST_START: tx_d = UART_START_BIT;
      ST_DATA:  tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = parity_d;
`endif
      default:  tx_d = UART_STOP_BIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      tx_q    <= UART_STOP_BIT;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign tx   = tx_q;
  assign done = done_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// Self-checking bench for uart_tx_core with CLK_PER_BAUD = 4.
// A frame-position model predicts tx/done every cycle; literal checks pin the
// model against hand-computed frames.
module tb_uart_tx_core;

  localparam int C = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYC = FRAME_BITS * C;

  logic       clk;
  logic       rst;
  logic [7:0] tx_byte;
  logic       start_send;
  logic       tx;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;
  int dut_done_cnt = 0;

  uart_tx_core #(.CLK_PER_BAUD(C)) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_byte   (tx_byte),
    .start_send(start_send),
    .tx        (tx),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model: position within the frame ----------------
  int       cyc = 0;
  bit       m_busy = 0;
  int       m_t = 0;
  logic [7:0] m_byte = '0;
  int       acc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 0;
      m_t    <= 0;
    end else if (!m_busy) begin
      if (start_send) begin
        m_busy <= 1;
        m_t    <= 0;
        m_byte <= tx_byte;
        acc_q.push_back(cyc);
      end
    end else if (m_t == FRAME_CYC - 1) begin
      m_busy <= 0;
    end else begin
      m_t <= m_t + 1;
    end
  end

  function automatic logic exp_tx_f();
    int b;
    if (!m_busy) return 1'b1;
    b = m_t / C;
    if (b == 0) return 1'b0;
    if (b <= 8) return m_byte[b-1];
`ifdef UART_TX_PARITY_EN
    if (b == 9) return ^m_byte;
`endif
    return 1'b1;
  endfunction

  function automatic logic exp_done_f();
    return m_busy && (m_t == FRAME_CYC - 1);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare, away from the rising edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("tx", {31'b0, tx}, {31'b0, exp_tx_f()});
      check("done", {31'b0, done}, {31'b0, exp_done_f()});
      if (done === 1'b1) dut_done_cnt++;
    end
  end

  // Send one pulsed request and capture the frame as seen on tx.
  task automatic capture_frame(input logic [7:0] b, output logic [9:0] bits,
                               output int lows, output int done_at, output int dones);
    bits = '0; lows = 0; done_at = -1; dones = 0;
    tx_byte = b;
    start_send = 1'b1;
    @(posedge clk);
    #1 start_send = 1'b0;
    for (int j = 0; j < 10 * C; j++) begin
      @(negedge clk);
      if (j % C == 1) bits[j / C] = tx;
      if (tx === 1'b0) lows++;
      if (done === 1'b1) begin
        done_at = j + 1;
        dones++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  logic [9:0] cap;
  int lows, done_at, dones, d0, na;

  initial begin
    rst = 1'b1;
    tx_byte = 8'h00;
    start_send = 1'b0;
    #2 rst = 1'b0;
    #1 chk_en = 1;

    // Reset held with a pending request: line stays idle.
    start_send = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_tx", {31'b0, tx}, 32'd1);
      check("rst_done", {31'b0, done}, 32'd0);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    start_send = 1'b0;
    repeat (2) @(posedge clk);
    #1;

`ifndef UART_TX_PARITY_EN
    // Single frame 0x30: 0, 0 0 0 0 1 1 0 0, 1.
    capture_frame(8'h30, cap, lows, done_at, dones);
    check("frame30_bits", {22'b0, cap}, 32'h260);
    check("frame30_done_at", done_at, 32'd40);
    check("frame30_done_cnt", dones, 32'd1);

    // Boundary bytes.
    capture_frame(8'h00, cap, lows, done_at, dones);
    check("frame00_lows", lows, 32'd36);
    capture_frame(8'hFF, cap, lows, done_at, dones);
    check("frameFF_lows", lows, 32'd4);
    check("frameFF_bits", {22'b0, cap}, 32'h3FE);
`endif

    // Continuous send: three back-to-back frames.
    d0 = dut_done_cnt;
    na = acc_q.size();
    tx_byte = 8'h30;
    start_send = 1'b1;
    @(posedge clk);
    repeat (2 * (FRAME_CYC + 1) + 1) @(posedge clk);
    #1 start_send = 1'b0;
    repeat (FRAME_CYC + 10) @(posedge clk);
    #1;
    check("cont_done_cnt", dut_done_cnt - d0, 32'd3);
    check("cont_accepts", acc_q.size() - na, 32'd3);
    check("cont_period1", acc_q[na+1] - acc_q[na], 32'd41 + ((FRAME_BITS - 10) * C));
    check("cont_period2", acc_q[na+2] - acc_q[na+1], 32'd41 + ((FRAME_BITS - 10) * C));

    // tx_byte changes mid-frame; next frame carries the new value.
    tx_byte = 8'h30;
    start_send = 1'b1;
    @(posedge clk);
    repeat (14) @(posedge clk);
    #1 tx_byte = 8'hFF;
    repeat (FRAME_CYC + 2) @(posedge clk);
    #1 start_send = 1'b0;
    check("chg_second_byte", {24'b0, m_byte}, 32'hFF);
    repeat (FRAME_CYC + 5) @(posedge clk);
    #1;

    // Reset at data bit 3, then a clean frame.
    d0 = dut_done_cnt;
    tx_byte = 8'h00;
    start_send = 1'b1;
    @(posedge clk);
    #1 start_send = 1'b0;
    repeat (17) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_tx", {31'b0, tx}, 32'd1);
    check("midrst_done", {31'b0, done}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (FRAME_CYC) @(posedge clk);
    #1;
    check("midrst_no_done", dut_done_cnt - d0, 32'd0);
`ifndef UART_TX_PARITY_EN
    capture_frame(8'hA5, cap, lows, done_at, dones);
    check("after_rst_bits", {22'b0, cap}, 32'h34A);
    check("after_rst_done_at", done_at, 32'd40);
`endif

    // Randomized traffic with data changes and occasional resets.
    for (int k = 0; k < 40; k++) begin
      int hold, gap;
      tx_byte = 8'($urandom);
      start_send = 1'b1;
      hold = $urandom_range(1, 60);
      for (int c = 0; c < hold; c++) begin
        @(posedge clk);
        #1;
        if ($urandom_range(0, 7) == 0) tx_byte = 8'($urandom);
        if ($urandom_range(0, 149) == 0) begin
          #2 rst = 1'b0;
          @(posedge clk);
          #1 rst = 1'b1;
        end
      end
      start_send = 1'b0;
      gap = $urandom_range(0, 50);
      repeat (gap) @(posedge clk);
      #1;
    end
    repeat (FRAME_CYC + 5) @(posedge clk);
    #1;
    check("final_idle_tx", {31'b0, tx}, 32'd1);

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
